// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the register trace source:
//   - out_kind encodings (cycle stamp, PC, register)
//   - record length and last slot index
//   - slot index -> register number mapping
// Build option: TRACE_T_REGS_EN adds $t0-$t3 to the record (14 words);
// without it the record ends after $s7 (10 words).
// -----------------------------------------------------------------------------
package trace_pkg;

   localparam logic [1:0] KIND_CYCLE = 2'd0;
   localparam logic [1:0] KIND_PC    = 2'd1;
   localparam logic [1:0] KIND_REG   = 2'd2;

`ifdef TRACE_T_REGS_EN
   localparam int REC_LEN = 14;
`else
   localparam int REC_LEN = 10;
`endif

   localparam int SLOT_W = 4;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(REC_LEN - 1);

   typedef enum logic {ST_IDLE, ST_SEND} state_e;

   // Slots 2..9 map to $s0-$s7 (16..23), slots 10..13 to $t0-$t3 (8..11).
   // Slots 0 and 1 are not register slots; their result is never used.
   function automatic logic [4:0] slot_reg(input logic [SLOT_W-1:0] slot);
      logic [SLOT_W-1:0] idx;
      idx = slot - 4'd2;
      if (idx < 4'd8) begin
         slot_reg = 5'd16 + {2'b00, idx[2:0]};
      end else begin
         slot_reg = 5'd8 + {3'b000, idx[1:0]};
      end
   endfunction

endpackage

// File: rtl/trace_slot_rom.sv
// -----------------------------------------------------------------------------
// trace_slot_rom
// Combinational decode of a record slot index into the output word's kind and
// tag, plus the register-file debug read address.
// Ports:
//   slot      in   slot index being loaded
//   load_en   in   the output register loads this slot in the current cycle
//   kind      out  out_kind for this slot
//   tag       out  register number for register slots, 0 otherwise
//   dbg_addr  out  register number while a register slot loads, else 0
// -----------------------------------------------------------------------------
module trace_slot_rom
   import trace_pkg::*;
(
   input  logic [SLOT_W-1:0] slot,
   input  logic              load_en,
   output logic [1:0]        kind,
   output logic [4:0]        tag,
   output logic [4:0]        dbg_addr
);

   always_comb begin
      kind     = KIND_REG;
      tag      = slot_reg(slot);
      dbg_addr = 5'd0;
      if (slot == 4'd0) begin
         kind = KIND_CYCLE;
         tag  = 5'd0;
      end else if (slot == 4'd1) begin
         kind = KIND_PC;
         tag  = 5'd0;
      end
      // Keep the read port quiet unless a register word is actually captured.
      if (load_en && kind == KIND_REG) begin
         dbg_addr = tag;
      end
   end

endmodule

// File: rtl/reg_trace_unit.sv
// -----------------------------------------------------------------------------
// reg_trace_unit
// Trace source for the MIPS pipeline. A trigger snapshots the free-running
// cycle counter and pc_in, then the unit walks the register file through the
// debug read port and streams {kind, tag, data} words over valid/ready.
// Build option: TRACE_T_REGS_EN (see trace_pkg) selects the 14-word record
// including $t0-$t3; the default record is 10 words.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   trigger, pc_in    record request and the PC captured with it
//   dbg_addr/dbg_data register-file debug read port (combinational data)
//   out_valid/ready   output handshake
//   out_kind/tag/data output word
//   busy              record in progress or last word not yet accepted
//   dropped           saturating count of triggers ignored while busy
// -----------------------------------------------------------------------------
module reg_trace_unit
   import trace_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic [DATA_W-1:0] pc_in,
   output logic [4:0]        dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_kind,
   output logic [4:0]        out_tag,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic [DROP_W-1:0] dropped
);

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DATA_W-1:0]   cyc_q, cyc_d;
   logic [DATA_W-1:0]   stamp_q, stamp_d;
   logic [DATA_W-1:0]   pc_q, pc_d;
   logic                out_valid_q, out_valid_d;
   logic [1:0]          out_kind_q, out_kind_d;
   logic [4:0]          out_tag_q, out_tag_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [DROP_W-1:0]   dropped_q, dropped_d;

   logic                load;
   logic                busy_w;
   logic [1:0]          rom_kind;
   logic [4:0]          rom_tag;

   // The output register is free when empty or being drained this cycle.
   assign load   = (state_q == ST_SEND) && (!out_valid_q || out_ready);
   assign busy_w = (state_q != ST_IDLE) || out_valid_q;

   trace_slot_rom u_rom (
      .slot     (slot_q),
      .load_en  (load),
      .kind     (rom_kind),
      .tag      (rom_tag),
      .dbg_addr (dbg_addr)
   );

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      cyc_d       = cyc_q + 1'b1;
      stamp_d     = stamp_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_kind_d  = out_kind_q;
      out_tag_d   = out_tag_q;
      out_data_d  = out_data_q;
      dropped_d   = dropped_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            // Waiting for the previous record's last word also counts as busy.
            if (trigger && !busy_w) begin
               pc_d    = pc_in;
               stamp_d = cyc_q;
               slot_d  = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_kind_d  = rom_kind;
               out_tag_d   = rom_tag;
               unique case (rom_kind)
                  KIND_CYCLE: out_data_d = stamp_q;
                  KIND_PC:    out_data_d = pc_q;
                  default:    out_data_d = dbg_data;
               endcase
               slot_d = slot_q + 1'b1;
               if (slot_q == LAST_SLOT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (trigger && busy_w && (dropped_q != '1)) begin
         dropped_d = dropped_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         cyc_q       <= '0;
         out_valid_q <= 1'b0;
         out_kind_q  <= KIND_CYCLE;
         out_tag_q   <= '0;
         out_data_q  <= '0;
         dropped_q   <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         cyc_q       <= cyc_d;
         out_valid_q <= out_valid_d;
         out_kind_q  <= out_kind_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
         dropped_q   <= dropped_d;
      end
      // Snapshot registers are only meaningful once a record starts.
      stamp_q <= stamp_d;
      pc_q    <= pc_d;
   end

   assign out_valid = out_valid_q;
   assign out_kind  = out_kind_q;
   assign out_tag   = out_tag_q;
   assign out_data  = out_data_q;
   assign busy      = busy_w;
   assign dropped   = dropped_q;

endmodule
